// File: rtl/data_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : data_store_buffer
// Brief    : Posted store buffer between the core memory stage and data_mem.
//            Stores are queued in a DEPTH-entry FIFO and drained in the
//            background. Loads are ordered behind queued stores and issued
//            as one-cycle request pulses. core_stall is derived from the
//            data_mem clk_stall handshake.
// Options  : DATA_SB_LOAD_BYPASS_EN - a load may pass queued stores whose
//            word address differs from the load's word address.
// Revision : 1.0 - initial release
// ============================================================================
module data_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic        core_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HI   = 2'd1,
    WAIT_LO   = 2'd2,
    LOAD_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [31:0] fifo_addr [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [3:0]  fifo_mask [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic op_is_load;     // the transaction currently in flight is a load
  logic full, empty;
  logic push, pop;
  logic load_ok;
  logic issue_load, issue_store;
  logic mem_done;       // data_mem finished the in-flight transaction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign mem_done = (state == WAIT_LO) && !mem_clk_stall;

  // A load wins over a simultaneous store request; a full FIFO blocks the store.
  assign push = memwrite && !memread && !full;
  assign pop  = mem_done && !op_is_load;

  // Core waits on any load until LOAD_DONE, and on a store that finds the FIFO full.
  assign core_stall = (memread && (state != LOAD_DONE)) ||
                      (memwrite && !memread && full);

`ifdef DATA_SB_LOAD_BYPASS_EN
  logic [DEPTH-1:0] hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [PTR_W-1:0] offs;
    // Distance from the head tells whether slot i holds a live entry.
    assign offs   = PTR_W'(i) - rd_ptr;
    assign hit[i] = (CNT_W'(offs) < count) && (fifo_addr[i][31:2] == addr[31:2]);
  end : g_cmp

  assign load_ok = (hit == '0);
`else
  assign load_ok = empty;
`endif

  // FIFO storage; contents need no reset because count qualifies them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= addr;
      fifo_data[wr_ptr] <= write_data;
      fifo_mask[wr_ptr] <= sign_mask;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state and issue decisions; IDLE never issues while data_mem is busy.
  always_comb begin
    state_next  = state;
    issue_load  = 1'b0;
    issue_store = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_clk_stall) begin
          if (memread && load_ok) begin
            issue_load = 1'b1;
            state_next = WAIT_HI;
          end else if (!empty) begin
            issue_store = 1'b1;
            state_next  = WAIT_HI;
          end
        end
      end
      WAIT_HI:   if (mem_clk_stall) state_next = WAIT_LO;
      WAIT_LO:   if (!mem_clk_stall) state_next = op_is_load ? LOAD_DONE : IDLE;
      LOAD_DONE: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Registered data_mem request; pulses last exactly one cycle after issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      op_is_load     <= 1'b0;
    end else begin
      mem_memread  <= issue_load;
      mem_memwrite <= issue_store;
      if (issue_load) begin
        mem_addr      <= addr;
        mem_sign_mask <= sign_mask;
        op_is_load    <= 1'b1;
      end else if (issue_store) begin
        mem_addr       <= fifo_addr[rd_ptr];
        mem_write_data <= fifo_data[rd_ptr];
        mem_sign_mask  <= fifo_mask[rd_ptr];
        op_is_load     <= 1'b0;
      end
    end
  end

  // Capture load data when data_mem releases clk_stall.
  always_ff @(posedge clk) begin
    if (rst)                         read_data <= '0;
    else if (mem_done && op_is_load) read_data <= mem_read_data;
  end

endmodule
`default_nettype wire
